// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/write-back sequencer for the mini CISC datapath.
// Handles NOP, PAUSE, HALT and reserved opcodes; keeps a saturating retired-instruction count.
module instr_sequencer #(
    parameter int FETCH_LAT = 1,
    parameter int RET_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             resume,
    input  logic [3:0]       opcode,
    input  logic [1:0]       rs1,
    input  logic [1:0]       rs2,
    output logic             pc_en,
    output logic             ir_load,
    output logic [3:0]       al_op,
    output logic [1:0]       rout,
    output logic             write,
    output logic             busy,
    output logic             paused,
    output logic             halted,
    output logic             illegal,
    output logic [RET_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_PAUSE, S_HALT
    } state_t;

    localparam logic [2:0] FETCH_LAST = 3'(FETCH_LAT - 1);

    state_t             state_q;
    logic [2:0]         cnt_q;
    logic [3:0]         al_op_q;
    logic [1:0]         rout_q;
    logic               illegal_q;
    logic [RET_W-1:0]   retired_q;

    logic               fetch_last;
    logic               dec_retire;
    logic               retire_d;
    logic [RET_W-1:0]   retired_d;

    // rs2 feeds the operand mux directly from the IR; the sequencer never needs it.
    logic               unused_rs2;
    assign unused_rs2 = ^rs2;

    always_comb begin
        fetch_last = (state_q == S_FETCH) && (cnt_q == FETCH_LAST);
        dec_retire = (state_q == S_DECODE) &&
                     (opcode == 4'h0 || opcode == 4'hC || opcode == 4'hD || opcode == 4'hE);
        // ALU ops count on entry to WB so the count already includes them during write-back.
        retire_d   = dec_retire || (state_q == S_EXEC);
        retired_d  = retired_q;
        if (retire_d && (retired_q != {RET_W{1'b1}}))
            retired_d = retired_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            al_op_q   <= '0;
            rout_q    <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (run) state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (fetch_last) begin
                        cnt_q   <= '0;
                        state_q <= S_DECODE;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                S_DECODE: begin
                    al_op_q <= opcode;
                    rout_q  <= rs1;
                    case (opcode)
                        4'h0:       state_q <= S_FETCH;
                        4'hC, 4'hD: begin
                            illegal_q <= 1'b1;
                            state_q   <= S_FETCH;
                        end
                        4'hE:       state_q <= S_PAUSE;
                        4'hF:       state_q <= S_HALT;
                        default:    state_q <= S_EXEC;
                    endcase
                end
                S_EXEC:  state_q <= S_WB;
                S_WB:    state_q <= S_FETCH;
                S_PAUSE: if (resume) state_q <= S_FETCH;
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ir_load = fetch_last;
        pc_en   = dec_retire || (state_q == S_WB);
        al_op   = (state_q == S_EXEC || state_q == S_WB) ? al_op_q : 4'h0;
        write   = (state_q == S_WB);
        rout    = rout_q;
        busy    = !(state_q == S_IDLE || state_q == S_PAUSE || state_q == S_HALT);
        paused  = (state_q == S_PAUSE);
        halted  = (state_q == S_HALT);
        illegal = illegal_q;
        retired = retired_q;
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: vector table, random instruction stream against a
// per-instruction expectation model, and directed pause/halt/reset/latency sequences.
module tb_instr_sequencer;

    localparam int FL = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, run, resume;
    logic [3:0]  opcode;
    logic [1:0]  rs1, rs2;
    logic        pc_en, ir_load, write, busy, paused, halted, illegal;
    logic [3:0]  al_op;
    logic [1:0]  rout;
    logic [15:0] retired;

    logic        b_rst, b_run, b_resume;
    logic [3:0]  b_opcode;
    logic [1:0]  b_rs1, b_rs2;
    logic        b_pc_en, b_ir_load, b_write, b_busy, b_paused, b_halted, b_illegal;
    logic [3:0]  b_al_op;
    logic [1:0]  b_rout;
    logic [1:0]  b_retired;

    instr_sequencer #(.FETCH_LAT(FL), .RET_W(16)) dut (
        .clk(clk), .rst(rst), .run(run), .resume(resume),
        .opcode(opcode), .rs1(rs1), .rs2(rs2),
        .pc_en(pc_en), .ir_load(ir_load), .al_op(al_op), .rout(rout),
        .write(write), .busy(busy), .paused(paused), .halted(halted),
        .illegal(illegal), .retired(retired)
    );

    instr_sequencer #(.FETCH_LAT(4), .RET_W(2)) dut_b (
        .clk(clk), .rst(b_rst), .run(b_run), .resume(b_resume),
        .opcode(b_opcode), .rs1(b_rs1), .rs2(b_rs2),
        .pc_en(b_pc_en), .ir_load(b_ir_load), .al_op(b_al_op), .rout(b_rout),
        .write(b_write), .busy(b_busy), .paused(b_paused), .halted(b_halted),
        .illegal(b_illegal), .retired(b_retired)
    );

    typedef struct {
        logic [3:0] op;
        logic [1:0] r1;
        logic [1:0] r2;
        int         ret;
        logic       ill;
    } vec_t;

    vec_t tbl[6];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mret  = 0;
    logic mill  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One cycle of the main DUT: drive at the falling edge, let outputs settle.
    task automatic cyc(input logic r, input logic ru, input logic re,
                       input logic [3:0] op, input logic [1:0] a, input logic [1:0] b);
        @(negedge clk);
        rst = r; run = ru; resume = re; opcode = op; rs1 = a; rs2 = b;
        #1;
    endtask

    task automatic cyc_rand();
        cyc(1'b0, 1'($urandom), 1'($urandom), 4'($urandom), 2'($urandom), 2'($urandom));
    endtask

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // Expected trace of one instruction, derived from its opcode class.
    task automatic run_instr(input logic [3:0] op, input logic [1:0] r1,
                             input logic [1:0] r2, input int plen);
        bit ret_dec, alu;
        ret_dec = (op == 4'h0 || op == 4'hC || op == 4'hD || op == 4'hE);
        alu     = (op >= 4'h1 && op <= 4'hB);
        for (int i = 0; i < FL; i++) begin
            cyc_rand();
            chk("fetch ir_load", ir_load, (i == FL - 1));
            chk("fetch pc_en", pc_en, 0);
            chk("fetch busy", busy, 1);
            if (i == 0) begin
                chk("retired", retired, mret);
                chk("illegal", illegal, mill);
            end
        end
        cyc(1'b0, 1'($urandom), 1'($urandom), op, r1, r2);
        chk("decode pc_en", pc_en, ret_dec);
        chk("decode write", write, 0);
        chk("decode al_op", al_op, 0);
        chk("decode ir_load", ir_load, 0);
        if (ret_dec) mret = sat16(mret + 1);
        if (op == 4'hC || op == 4'hD) mill = 1'b1;
        if (alu) begin
            cyc_rand();
            chk("exec al_op", al_op, op);
            chk("exec write", write, 0);
            chk("exec pc_en", pc_en, 0);
            mret = sat16(mret + 1);
            cyc_rand();
            chk("wb write", write, 1);
            chk("wb al_op", al_op, op);
            chk("wb rout", rout, r1);
            chk("wb pc_en", pc_en, 1);
            chk("wb retired", retired, mret);
        end
        if (op == 4'hE) begin
            for (int k = 0; k < plen; k++) begin
                cyc(1'b0, 1'($urandom), 1'b0, 4'($urandom), 2'($urandom), 2'($urandom));
                chk("pause paused", paused, 1);
                chk("pause busy", busy, 0);
                chk("pause pc_en", pc_en, 0);
            end
            cyc(1'b0, 1'($urandom), 1'b1, 4'($urandom), 2'($urandom), 2'($urandom));
            chk("resume cycle paused", paused, 1);
        end
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; resume = 1'b0; opcode = '0; rs1 = '0; rs2 = '0;
        b_rst = 1'b1; b_run = 1'b0; b_resume = 1'b0; b_opcode = '0; b_rs1 = '0; b_rs2 = '0;

        tbl[0] = '{4'h3, 2'd2, 2'd1, 1, 1'b0};
        tbl[1] = '{4'h0, 2'd1, 2'd3, 2, 1'b0};
        tbl[2] = '{4'hC, 2'd3, 2'd0, 3, 1'b1};
        tbl[3] = '{4'h5, 2'd0, 2'd2, 4, 1'b1};
        tbl[4] = '{4'hD, 2'd2, 2'd2, 5, 1'b1};
        tbl[5] = '{4'hB, 2'd3, 2'd1, 6, 1'b1};

        // Reset and idle
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 2'd0);
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'($urandom), 4'($urandom), 2'($urandom), 2'($urandom));
            chk("idle outputs", {pc_en, ir_load, al_op, rout, write, busy, paused,
                                 halted, illegal, retired}, 0);
        end
        cyc(1'b0, 1'b1, 1'b0, 4'h0, 2'd0, 2'd0);
        chk("start cycle busy", busy, 0);
        chk("start cycle ir_load", ir_load, 0);

        // Vector table
        for (int t = 0; t < 6; t++) begin
            run_instr(tbl[t].op, tbl[t].r1, tbl[t].r2, 0);
            @(posedge clk); #1;
            chk("table retired", retired, tbl[t].ret);
            chk("table illegal", illegal, tbl[t].ill);
        end

        // Random instruction stream (no HALT)
        for (int n = 0; n < 150; n++)
            run_instr(4'($urandom_range(0, 14)), 2'($urandom), 2'($urandom),
                      int'($urandom_range(0, 3)));

        // Long pause, then a NOP shows FETCH/busy right after resume
        run_instr(4'hE, 2'd0, 2'd0, 10);
        run_instr(4'h0, 2'd0, 2'd0, 0);

        // Halt is absorbing
        run_instr(4'hF, 2'd1, 2'd1, 0);
        for (int k = 0; k < 6; k++) begin
            cyc_rand();
            chk("halt halted", halted, 1);
            chk("halt pc_en", pc_en, 0);
            chk("halt busy", busy, 0);
            chk("halt retired", retired, mret);
        end

        // Reset during EXEC
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 2'd0);
        cyc(1'b0, 1'b1, 1'b0, 4'h0, 2'd0, 2'd0);
        chk("post-halt reset halted", halted, 0);
        cyc_rand();
        chk("rst seq ir_load", ir_load, 1);
        cyc(1'b0, 1'b1, 1'b0, 4'h3, 2'd2, 2'd1);
        cyc(1'b1, 1'b1, 1'b0, 4'h3, 2'd2, 2'd1);
        chk("rst seq exec al_op", al_op, 3);
        cyc(1'b0, 1'b0, 1'b0, 4'h3, 2'd2, 2'd1);
        chk("rst exec busy", busy, 0);
        chk("rst exec write", write, 0);
        chk("rst exec retired", retired, 0);
        chk("rst exec illegal", illegal, 0);

        // FETCH_LAT=4, RET_W=2: latency and saturation
        @(negedge clk); b_rst = 1'b0; b_run = 1'b1; #1;
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk); b_opcode = 4'($urandom); #1;
                chk("fl4 ir_load", b_ir_load, (i == 3));
                chk("fl4 pc_en", b_pc_en, 0);
                if (i == 0) chk("fl4 retired", b_retired, (n > 3) ? 3 : n);
            end
            @(negedge clk); b_opcode = 4'h0; #1;
            chk("fl4 decode pc_en", b_pc_en, 1);
        end
        @(posedge clk); #1;
        chk("fl4 saturated retired", b_retired, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
